tetris_move_scheduler: RTL and testbench
========================================

# tetris_move_scheduler

Sequences all piece-movement commands for the Tetris game engine. It turns the USB keyboard keycode exported by the Nios II/USB subsystem into one-shot and auto-repeat move requests. It generates level-dependent gravity ticks and arbitrates both sources onto a single valid/ready command stream consumed by the board-update logic. The block sits between the SoC `keycode` export and the game engine, in the system clock domain.

## Interface
Parameters:
- `GRAVITY_BASE`, 25_000_000: gravity period in cycles at level 0.
- `LEVEL_STEP`, 2_000_000: period reduction per level.
- `GRAVITY_MIN`, 2_500_000: floor on the gravity period.
- `DAS_DELAY`, 8_000_000: hold cycles before auto-repeat starts.
- `ARR_PERIOD`, 2_500_000: auto-repeat interval in cycles.
- `CW`, 25: width of all timers; every parameter must be < 2^CW.

Ports:
- `clk_clk` in 1: system clock.
- `reset_reset_n` in 1: asynchronous active-low reset.
- `keycode` in 8: HID usage code of the held key; 0 means none.
- `level` in 4: current game level, 0–15.
- `run` in 1: game active; 0 pauses and flushes.
- `cmd_valid` out 1: command offered.
- `cmd` out 3: 1=LEFT, 2=RIGHT, 3=ROTATE, 4=SOFT_DROP, 5=HARD_DROP, 6=GRAVITY; 0 when idle.
- `cmd_ready` in 1: engine accepts the command.
- `grav_period` out CW: active gravity period, for debug and HEX display.

## Operation
- Key map: 0x04→LEFT, 0x07→RIGHT, 0x1A→ROTATE, 0x16→SOFT_DROP, 0x2C→HARD_DROP. Any other code is treated as 0.
- `keycode` is registered into `k_q` every cycle. A press event occurs when `k_q` is a mapped code ≠ previous `k_q`. A key change restarts the DAS timer.
- ROTATE and HARD_DROP: one event per press, no repeat.
- LEFT, RIGHT, SOFT_DROP auto-repeat:
  - One event on press.
  - While the same code is held, DAS counts `DAS_DELAY` cycles.
  - After that, one repeat event every `ARR_PERIOD` cycles.
- Gravity timer:
  - Counts down from `grav_period`-1 and reloads at 0, setting the gravity pending flag.
  - `grav_period` = max(GRAVITY_BASE − level·LEVEL_STEP, GRAVITY_MIN). Computed with CW+4-bit signed arithmetic, saturating, and registered.
  - A `level` change takes effect at the next reload.
- Pending flags:
  - `pend_key` holds a 3-bit code and `pend_grav` is a single bit.
  - A new key event overwrites an unissued `pend_key`; the latest key wins.
  - A gravity tick while `pend_grav` is already set is dropped (coalesced).
- FSM states IDLE and ISSUE:
  - IDLE→ISSUE when either flag is set. The winner is latched into `cmd`, `cmd_valid` is set, and the winner's flag is cleared.
  - Arbitration: key beats gravity, except that gravity wins if the previous issued command was a key (alternating priority, no starvation).
  - ISSUE→IDLE on `cmd_valid && cmd_ready`. `cmd` and `cmd_valid` are held stable until then.
- Accepting HARD_DROP reloads the gravity timer, giving the new piece a full period.
- `run`=0:
  - Timers hold at reload value and both flags are cleared.
  - No new events are generated.
  - A command already in ISSUE stays offered until accepted.
- Simultaneous pending-set and issue of the same flag in one cycle: the set wins, so the flag stays 1.

## Timing
- Reset values: `cmd_valid`=0, `cmd`=0, `grav_period`=GRAVITY_BASE, state IDLE, flags 0, `k_q`=0, timers at reload.
- Key latency:
  - Edge E0 samples the new `keycode` into `k_q`.
  - E1 sets `pend_key`.
  - E2 enters ISSUE; `cmd_valid` is high after E2.
- Gravity latency: `cmd_valid` rises 1 edge after `pend_grav` is set, when IDLE.
- Throughput: at most one command per 2 cycles (accept edge, then one IDLE cycle).
- Repeat spacing:
  - The first repeat is `DAS_DELAY` cycles after the press event.
  - Subsequent repeats are exactly `ARR_PERIOD` cycles apart, independent of `cmd_ready` stalls (coalesced).
- Reset asserted mid-ISSUE: `cmd_valid` drops immediately (asynchronously).

## Test plan
Parameters for all scenarios: GRAVITY_BASE=100, LEVEL_STEP=10, GRAVITY_MIN=20, DAS_DELAY=30, ARR_PERIOD=10.
- Reset, `run`=1, `keycode`=0, `cmd_ready`=1, `level`=0 → GRAVITY (6) offered every 100 cycles; `grav_period`=100.
- `level`=9 → `grav_period`=20 (floor applied, not 10). `level`=3 → 70, effective from the next reload.
- Hold 0x04 for 65 cycles → LEFT at press, then at +30, +40, +50, +60 (5 total). Hold 0x1A for 65 cycles → exactly one ROTATE.
- `cmd_ready`=0 for 200 cycles while holding 0x07:
  - RIGHT is offered and held stable throughout.
  - At most one extra RIGHT and one GRAVITY are issued after release of the stall, alternating key/gravity.
- Press 0x2C at cycle 50 of a gravity period → HARD_DROP accepted. The next GRAVITY arrives 100 cycles after acceptance.
- Drop `run` while ISSUE has LEFT and `cmd_ready`=0:
  - LEFT is retained until ready.
  - No further commands are issued.
  - After `run`=1, gravity restarts with a full period.

Source files
------------

// File: rtl/tetris_move_scheduler.sv
// tetris_move_scheduler: turns held keycodes and level-timed gravity into one valid/ready move command stream
module tetris_move_scheduler #(
    parameter int GRAVITY_BASE = 25_000_000,
    parameter int LEVEL_STEP   = 2_000_000,
    parameter int GRAVITY_MIN  = 2_500_000,
    parameter int DAS_DELAY    = 8_000_000,
    parameter int ARR_PERIOD   = 2_500_000,
    parameter int CW           = 25
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    input  logic [7:0]    keycode,
    input  logic [3:0]    level,
    input  logic          run,
    output logic          cmd_valid,
    output logic [2:0]    cmd,
    input  logic          cmd_ready,
    output logic [CW-1:0] grav_period
);
    localparam logic [2:0] LEFT = 3'd1, RIGHT = 3'd2, ROTATE = 3'd3, SOFT = 3'd4, HARD = 3'd5, GRAV = 3'd6;
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state, state_d;
    logic [7:0] k_q, k_prev;
    logic [2:0] code, pend_key, cmd_d;
    logic pend_grav, last_key, last_key_d, clr_key, clr_grav;
    logic [CW-1:0] das_cnt, grav_cnt;
    logic signed [CW+3:0] gp_raw;
    logic key_change, press, repeat_ev, key_ev, tick, hd_accept;

    function automatic logic [2:0] map_key(input logic [7:0] k);
        return k == 8'h04 ? LEFT : k == 8'h07 ? RIGHT : k == 8'h1A ? ROTATE :
               k == 8'h16 ? SOFT : k == 8'h2C ? HARD : 3'd0;
    endfunction

    assign code       = map_key(k_q);
    assign key_change = k_q != k_prev;
    assign press      = run && |code && key_change;
    assign repeat_ev  = run && !key_change && das_cnt == '0 && (code == LEFT || code == RIGHT || code == SOFT);
    assign key_ev     = press || repeat_ev;
    assign tick       = run && grav_cnt == '0;
    assign hd_accept  = state == ISSUE && cmd_ready && cmd == HARD;
    assign cmd_valid  = state == ISSUE;
    assign gp_raw     = $signed((CW+4)'(GRAVITY_BASE) - (CW+4)'(level) * (CW+4)'(LEVEL_STEP));

    // Gravity wins a tie only when the last issued command was a key, so neither source starves
    always_comb begin
        state_d    = state;
        cmd_d      = cmd;
        last_key_d = last_key;
        clr_key    = 1'b0;
        clr_grav   = 1'b0;
        if (state == ISSUE) begin
            state_d = cmd_ready ? IDLE : ISSUE;
            cmd_d   = cmd_ready ? 3'd0 : cmd;
        end else if (run && (|pend_key || pend_grav)) begin
            clr_grav   = pend_grav && (!(|pend_key) || last_key);
            clr_key    = !clr_grav;
            cmd_d      = clr_grav ? GRAV : pend_key;
            last_key_d = !clr_grav;
            state_d    = ISSUE;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= IDLE;
            cmd      <= '0;
            last_key <= 1'b0;
        end else begin
            state    <= state_d;
            cmd      <= cmd_d;
            last_key <= last_key_d;
        end
    end

    // A fresh event on the same cycle as an issue keeps its flag set
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            k_q         <= '0;
            k_prev      <= '0;
            pend_key    <= '0;
            pend_grav   <= 1'b0;
            das_cnt     <= CW'(DAS_DELAY - 1);
            grav_cnt    <= CW'(GRAVITY_BASE - 1);
            grav_period <= CW'(GRAVITY_BASE);
        end else begin
            k_q         <= |map_key(keycode) ? keycode : 8'h00;
            k_prev      <= k_q;
            pend_key    <= !run ? 3'd0 : key_ev ? code : clr_key ? 3'd0 : pend_key;
            pend_grav   <= run && (tick || (pend_grav && !clr_grav));
            das_cnt     <= !run || key_change ? CW'(DAS_DELAY - 1) :
                           das_cnt == '0 ? CW'(ARR_PERIOD - 1) : das_cnt - 1'b1;
            grav_cnt    <= !run || hd_accept || grav_cnt == '0 ? grav_period - 1'b1 : grav_cnt - 1'b1;
            grav_period <= gp_raw < $signed((CW+4)'(GRAVITY_MIN)) ? CW'(GRAVITY_MIN) : gp_raw[CW-1:0];
        end
    end
endmodule

// File: tb/tb_tetris_move_scheduler.sv
// tb_tetris_move_scheduler: directed and randomized checks of the move scheduler against an event-timing model
module tb_tetris_move_scheduler;
    localparam int GB = 100, LS = 10, GM = 20, DD = 30, AP = 10, CW = 25;
    logic clk = 1'b0, rst_n = 1'b1, run = 1'b0, cmd_ready = 1'b0;
    logic [7:0] keycode = '0;
    logic [3:0] level = '0;
    logic cmd_valid;
    logic [2:0] cmd;
    logic [CW-1:0] grav_period;
    logic [CW+3:0] obs;
    int n_tests = 0, n_fail = 0;
    int cyc, anchor, gdue, m_gp;
    logic [7:0] m_kq, m_kprev;
    logic [2:0] m_pk, m_cmd, d_cmd;
    logic m_pg, m_issue, m_last_key, d_acc;

    tetris_move_scheduler #(
        .GRAVITY_BASE(GB), .LEVEL_STEP(LS), .GRAVITY_MIN(GM),
        .DAS_DELAY(DD), .ARR_PERIOD(AP), .CW(CW)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .keycode(keycode), .level(level), .run(run),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .grav_period(grav_period)
    );

    assign obs = {cmd_valid, cmd, grav_period};
    always #5 clk = ~clk;

    function automatic logic [2:0] m_code(input logic [7:0] k);
        case (k)
            8'h04:   return 3'd1;
            8'h07:   return 3'd2;
            8'h1A:   return 3'd3;
            8'h16:   return 3'd4;
            8'h2C:   return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic int gp_of(input int lv);
        return GB - lv * LS < GM ? GM : GB - lv * LS;
    endfunction

    function automatic logic [CW+3:0] mexp();
        return {m_issue, m_cmd, CW'(m_gp)};
    endfunction

    task automatic m_reset();
        cyc = 0;
        anchor = 0;
        gdue = GB;
        m_gp = GB;
        m_kq = '0;
        m_kprev = '0;
        m_pk = '0;
        m_pg = 1'b0;
        m_issue = 1'b0;
        m_cmd = '0;
        m_last_key = 1'b0;
    endtask

    // Model: events from elapsed time since the last key change / gravity reload, then one arbitration step
    task automatic step();
        logic [2:0] c, ev;
        logic chg, tick, gwin;
        int n, gp_old;
        d_acc = cmd_valid && cmd_ready;
        d_cmd = cmd;
        @(posedge clk);
        cyc++;
        c = m_code(m_kq);
        chg = m_kq != m_kprev;
        n = cyc - anchor;
        gp_old = m_gp;
        ev = '0;
        if (run && c != 0 && chg) ev = c;
        if (run && !chg && (c == 1 || c == 2 || c == 4) && n >= DD && (n - DD) % AP == 0) ev = c;
        tick = run && cyc == gdue;
        if (!run || chg) anchor = cyc;
        if (!run || tick || (m_issue && cmd_ready && m_cmd == 3'd5)) gdue = cyc + gp_old;
        if (m_issue) begin
            if (cmd_ready) begin
                m_issue = 1'b0;
                m_cmd = '0;
            end
        end else if (run && (m_pk != 0 || m_pg)) begin
            gwin = m_pg && (m_pk == 0 || m_last_key);
            m_cmd = gwin ? 3'd6 : m_pk;
            m_issue = 1'b1;
            m_last_key = !gwin;
            if (gwin) m_pg = 1'b0;
            else m_pk = '0;
        end
        if (ev != 0) m_pk = ev;
        if (tick) m_pg = 1'b1;
        if (!run) begin
            m_pk = '0;
            m_pg = 1'b0;
        end
        m_kprev = m_kq;
        m_kq = m_code(keycode) != 0 ? keycode : 8'h00;
        m_gp = gp_of(int'(level));
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        keycode = '0;
        level = '0;
        run = 1'b1;
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        m_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #2;
        n_tests++;
        if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_async valid got %b want 0", cmd_valid); end
        do_reset();
        n_tests++;
        if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", cmd_valid); end
        n_tests++;
        if (cmd !== 3'd0) begin n_fail++; $display("FAIL reset_cmd got %0d want 0", cmd); end
        n_tests++;
        if (grav_period !== CW'(GB)) begin n_fail++; $display("FAIL reset_gp got %0d want %0d", grav_period, GB); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL reset_run cyc=%0d got %h want %h", cyc, obs, mexp()); end
        end
    endtask

    task automatic test_gravity();
        int rises[$];
        logic pv = 1'b0;
        do_reset();
        for (int i = 0; i < 320; i++) begin
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL gravity cyc=%0d got %h want %h", cyc, obs, mexp()); end
            if (cmd_valid && !pv && cmd == 3'd6) rises.push_back(cyc);
            pv = cmd_valid;
        end
        n_tests++;
        if (rises.size() != 3) begin n_fail++; $display("FAIL gravity_count got %0d want 3", rises.size()); end
        else begin
            n_tests++;
            if (rises[0] != GB + 1) begin n_fail++; $display("FAIL gravity_first got %0d want %0d", rises[0], GB + 1); end
            for (int i = 1; i < 3; i++) begin
                n_tests++;
                if (rises[i] - rises[i-1] != GB) begin n_fail++; $display("FAIL gravity_gap got %0d want %0d", rises[i] - rises[i-1], GB); end
            end
        end
    endtask

    task automatic test_level();
        int rises[$];
        logic pv = 1'b0;
        do_reset();
        level = 4'd9;
        for (int i = 0; i < 150; i++) begin
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL level9 cyc=%0d got %h want %h", cyc, obs, mexp()); end
            if (i == 0 && grav_period !== CW'(GM)) begin n_fail++; $display("FAIL level9_floor got %0d want %0d", grav_period, GM); end
            pv = cmd_valid;
        end
        level = 4'd3;
        for (int i = 0; i < 250; i++) begin
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL level3 cyc=%0d got %h want %h", cyc, obs, mexp()); end
            if (cmd_valid && !pv && cmd == 3'd6) rises.push_back(cyc);
            pv = cmd_valid;
        end
        n_tests++;
        if (grav_period !== CW'(GB - 3 * LS)) begin n_fail++; $display("FAIL level3_gp got %0d want %0d", grav_period, GB - 3 * LS); end
        n_tests++;
        if (rises.size() < 2) begin n_fail++; $display("FAIL level3_rises got %0d want >=2", rises.size()); end
        else begin
            n_tests++;
            if (rises[0] != GB + 3 * GM + 1) begin n_fail++; $display("FAIL level3_first got %0d want %0d", rises[0], GB + 3 * GM + 1); end
            n_tests++;
            if (rises[1] - rises[0] != GB - 3 * LS) begin n_fail++; $display("FAIL level3_gap got %0d want %0d", rises[1] - rises[0], GB - 3 * LS); end
        end
        level = 4'd15;
        step();
        n_tests++;
        if (grav_period !== CW'(GM)) begin n_fail++; $display("FAIL level15_floor got %0d want %0d", grav_period, GM); end
    endtask

    task automatic test_left_repeat();
        int rises[$];
        logic pv = 1'b0;
        do_reset();
        keycode = 8'h04;
        for (int i = 0; i < 80; i++) begin
            if (i == 65) keycode = 8'h00;
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL left cyc=%0d got %h want %h", cyc, obs, mexp()); end
            if (cmd_valid && !pv && cmd == 3'd1) rises.push_back(cyc);
            pv = cmd_valid;
        end
        n_tests++;
        if (rises.size() != 5) begin n_fail++; $display("FAIL left_count got %0d want 5", rises.size()); end
        else begin
            n_tests++;
            if (rises[0] != 3) begin n_fail++; $display("FAIL left_latency got %0d want 3", rises[0]); end
            for (int i = 1; i < 5; i++) begin
                n_tests++;
                if (rises[i] - rises[i-1] != (i == 1 ? DD : AP)) begin
                    n_fail++;
                    $display("FAIL left_gap%0d got %0d want %0d", i, rises[i] - rises[i-1], i == 1 ? DD : AP);
                end
            end
        end
    endtask

    task automatic test_rotate();
        int count = 0;
        logic pv = 1'b0;
        do_reset();
        keycode = 8'h1A;
        for (int i = 0; i < 80; i++) begin
            if (i == 65) keycode = 8'h00;
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL rotate cyc=%0d got %h want %h", cyc, obs, mexp()); end
            if (cmd_valid && !pv && cmd == 3'd3) count++;
            pv = cmd_valid;
        end
        n_tests++;
        if (count != 1) begin n_fail++; $display("FAIL rotate_count got %0d want 1", count); end
    endtask

    task automatic test_stall();
        logic [2:0] acc[$];
        do_reset();
        cmd_ready = 1'b0;
        keycode = 8'h07;
        for (int i = 0; i < 200; i++) begin
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL stall cyc=%0d got %h want %h", cyc, obs, mexp()); end
            if (cyc >= 3) begin
                n_tests++;
                if (!(cmd_valid === 1'b1 && cmd === 3'd2)) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc=%0d got v=%b cmd=%0d want v=1 cmd=2", cyc, cmd_valid, cmd);
                end
            end
        end
        keycode = 8'h00;
        cmd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL stall_drain cyc=%0d got %h want %h", cyc, obs, mexp()); end
            if (d_acc) acc.push_back(d_cmd);
        end
        n_tests++;
        if (acc.size() != 3) begin n_fail++; $display("FAIL stall_accepts got %0d want 3", acc.size()); end
        else begin
            n_tests++;
            if (!(acc[0] == 3'd2 && acc[1] == 3'd6 && acc[2] == 3'd2)) begin
                n_fail++;
                $display("FAIL stall_order got %0d,%0d,%0d want 2,6,2", acc[0], acc[1], acc[2]);
            end
        end
    endtask

    task automatic test_hard_drop();
        int hd = 0, gr = 0;
        logic pv = 1'b0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (cyc == GB + GB / 2) keycode = 8'h2C;
            if (cyc == GB + GB / 2 + 12) keycode = 8'h00;
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL hard_drop cyc=%0d got %h want %h", cyc, obs, mexp()); end
            if (d_acc && d_cmd == 3'd5 && hd == 0) hd = cyc;
            if (hd != 0 && gr == 0 && cmd_valid && !pv && cmd == 3'd6) gr = cyc;
            pv = cmd_valid;
        end
        n_tests++;
        if (hd == 0 || gr - hd != GB + 1) begin
            n_fail++;
            $display("FAIL hard_drop_regrav got accept=%0d grav=%0d want grav=accept+%0d", hd, gr, GB + 1);
        end
    endtask

    task automatic test_run_pause();
        int r, gr = 0;
        logic pv = 1'b0;
        do_reset();
        cmd_ready = 1'b0;
        keycode = 8'h04;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL pause_pre cyc=%0d got %h want %h", cyc, obs, mexp()); end
        end
        keycode = 8'h00;
        run = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            n_tests++;
            if (!(cmd_valid === 1'b1 && cmd === 3'd1)) begin
                n_fail++;
                $display("FAIL pause_hold cyc=%0d got v=%b cmd=%0d want v=1 cmd=1", cyc, cmd_valid, cmd);
            end
        end
        cmd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL pause_idle cyc=%0d got %h want %h", cyc, obs, mexp()); end
            if (i > 0 && cmd_valid !== 1'b0) begin n_fail++; $display("FAIL pause_quiet cyc=%0d got v=%b want 0", cyc, cmd_valid); end
        end
        run = 1'b1;
        r = cyc;
        for (int i = 0; i < 110; i++) begin
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL pause_resume cyc=%0d got %h want %h", cyc, obs, mexp()); end
            if (gr == 0 && cmd_valid && !pv && cmd == 3'd6) gr = cyc;
            pv = cmd_valid;
        end
        n_tests++;
        if (gr != r + GB + 1) begin n_fail++; $display("FAIL pause_regrav got %0d want %0d", gr, r + GB + 1); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cmd_ready = 1'b0;
        keycode = 8'h04;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL async_pre cyc=%0d got %h want %h", cyc, obs, mexp()); end
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got %b want 0", cmd_valid); end
        n_tests++;
        if (cmd !== 3'd0) begin n_fail++; $display("FAIL async_cmd got %0d want 0", cmd); end
    endtask

    task automatic test_random();
        logic [7:0] codes[8] = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h16, 8'h2C, 8'h05, 8'hFF};
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) keycode = codes[$urandom_range(7)];
            cmd_ready = $urandom_range(3) != 0;
            if ($urandom_range(149) == 0) level = 4'($urandom_range(15));
            if ($urandom_range(299) == 0) run = !run;
            step();
            n_tests++;
            if (obs !== mexp()) begin n_fail++; $display("FAIL random cyc=%0d got %h want %h", cyc, obs, mexp()); end
        end
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_level();
        test_left_repeat();
        test_rotate();
        test_stall();
        test_hard_drop();
        test_run_pause();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
